cpu_controller: RTL
===================

// Module: cpu_controller
// PURPOSE
//  Multi-cycle fetch/decode/execute sequencer that drives the register-file/ALU datapath.
//  Fetches 20-bit instructions over a req/valid memory handshake.
//  Generates RA1/RA2/WA/immediate/ALUControl/ALUSrc/write_enable and consumes Zero for branches.
//  Sits between instruction memory and the datapath; together they form the 8-bit CPU core.
// PARAMETERS
//  PC_W      8    program counter / instruction address width (1..8; branch target = imm[PC_W-1:0])
//  RESET_PC  0    PC value loaded on reset
// PORTS
//  CLK           in   1     single clock, rising edge
//  RESET_N       in   1     asynchronous, active-low reset
//  imem_req      out  1     fetch request, held high until imem_valid
//  imem_addr     out  PC_W  fetch address (= pc)
//  imem_valid    in   1     imem_rdata valid this cycle; ignored unless in FETCH with imem_req=1
//  imem_rdata    in   20    instruction: op[19:16] wa[15:12] ra1[11:8] imm[7:0], ra2=imm[3:0]
//  Zero          in   1     datapath ALU zero flag
//  RA1,RA2,WA    out  4     register addresses (from IR)
//  immediate     out  8     IR imm field
//  ALUControl    out  2     00 ADD, 01 SUB, 10 AND, 11 OR
//  ALUSrc        out  1     1 = immediate as ALU srcB
//  write_enable  out  1     register write strobe
//  pc_out        out  PC_W  current PC
//  halted        out  1     core stopped (HALT or illegal opcode)
//  illegal       out  1     sticky: illegal opcode seen
// BEHAVIOUR
//  - Reset (async, immediate): state=FETCH, pc=RESET_PC, ir=0, illegal=0, halted=0.
//    All datapath outputs 0; write_enable=0 and imem_req=0 asynchronously.
//    FETCH begins the cycle after RESET_N deasserts.
//  - Opcodes: 0 NOP; 1 ADD, 2 SUB, 3 AND, 4 OR (ALUSrc=0); 5 ADDI, 6 SUBI, 7 ANDI, 8 ORI (ALUSrc=1).
//    9 BEQ, A BNE: SUB with ALUSrc=0, branch target imm. B JMP. F HALT. C/D/E illegal.
//  - Datapath outputs decode combinationally from the registered IR only; stable from DECODE through EXECUTE.
//  - States:
//    FETCH: imem_req=1, imem_addr=pc. On imem_valid, ir<=imem_rdata -> DECODE.
//    DECODE: one cycle, outputs settle. Illegal opcode -> HALT with illegal<=1. Otherwise -> EXECUTE.
//    EXECUTE: one cycle.
//      ALU ops: write_enable=1 (register written at the closing edge).
//      BEQ: pc<=imm if Zero, else pc+1. BNE: pc<=imm if !Zero, else pc+1. JMP: pc<=imm.
//      Others: pc<=pc+1. Then -> FETCH.
//    HALT: halted=1, imem_req=0, write_enable=0. Exits only by reset.
//  - write_enable is high only in EXECUTE of an ALU op: exactly one cycle per instruction.
//  - pc+1 wraps modulo 2^PC_W. Branch/jump target truncates imm to PC_W bits.
//  - Minimum instruction period is 3 cycles; FETCH stretches for imem wait states.
//  - Zero is sampled only at the EXECUTE edge of BEQ/BNE.
// CONFIGURATION
//  CPU_CTRL_PERF_CNT_EN defined:
//    adds port retired_count out 16, reset 0.
//    Increments by 1 at every EXECUTE edge (NOP/branch included); wraps at 0xFFFF.
//  Not defined: port and counter absent; remaining behaviour is identical.
// STRUCTURE
//  - cpu_ctrl_pkg: opcode_e (4-bit enum), state_e (FETCH/DECODE/EXECUTE/HALT),
//    ALU_ADD/ALU_SUB/ALU_AND/ALU_OR constants, INSTR_W=20, field position constants.
//  - Sub-module instr_decoder (combinational): ir -> RA1/RA2/WA/immediate/ALUControl/ALUSrc,
//    is_alu, is_branch, is_illegal.
//  - Top level holds the FSM, pc, ir, flags and the optional counter.
// TESTING
//  1. Reset, imem returns 0x5_1_0_07 (ADDI r1=r0+7) with 0 wait states
//     -> imem_req at cycle 1; write_enable=1 with WA=1, ALUSrc=1, immediate=0x07, ALUControl=00
//        exactly 2 cycles later; pc_out=1.
//  2. imem_valid delayed 3 cycles -> imem_req held with imem_addr constant;
//     a spurious imem_valid during DECODE is ignored.
//  3. BEQ imm=0x20, Zero=1 -> pc_out=0x20, write_enable never high;
//     repeat with Zero=0 -> pc_out=old+1. BNE gives the inverse results.
//  4. PC_W=4, pc=0xF executes NOP -> pc_out wraps to 0x0; JMP imm=0x3A -> pc_out=0xA.
//  5. Opcode 0xC -> illegal=1, halted=1, imem_req stays 0 for 20 cycles;
//     HALT (0xF) -> halted=1, illegal=0.
//  6. RESET_N pulled low mid-EXECUTE of ADD -> write_enable drops the same cycle, pc_out=RESET_PC.
//     With CPU_CTRL_PERF_CNT_EN: retired_count=0 after reset and =N after N instructions.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the cpu_controller sequencer.
// Instruction layout: op[19:16] wa[15:12] ra1[11:8] imm[7:0], ra2 = imm[3:0].
package cpu_ctrl_pkg;

  localparam int INSTR_W = 20;

  localparam int OP_MSB  = 19;
  localparam int OP_LSB  = 16;
  localparam int WA_MSB  = 15;
  localparam int WA_LSB  = 12;
  localparam int RA1_MSB = 11;
  localparam int RA1_LSB = 8;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;
  localparam int RA2_MSB = 3;
  localparam int RA2_LSB = 0;

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_ADD   = 4'h1,
    OP_SUB   = 4'h2,
    OP_AND   = 4'h3,
    OP_OR    = 4'h4,
    OP_ADDI  = 4'h5,
    OP_SUBI  = 4'h6,
    OP_ANDI  = 4'h7,
    OP_ORI   = 4'h8,
    OP_BEQ   = 4'h9,
    OP_BNE   = 4'hA,
    OP_JMP   = 4'hB,
    OP_ILL_C = 4'hC,
    OP_ILL_D = 4'hD,
    OP_ILL_E = 4'hE,
    OP_HALT  = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_DECODE  = 2'd1,
    ST_EXECUTE = 2'd2,
    ST_HALT    = 2'd3
  } state_e;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  // Map an opcode to the ALU operation it requests; branches compare by subtracting.
  function automatic logic [1:0] alu_ctrl_of(input opcode_e op);
    logic [1:0] ctrl;
    ctrl = ALU_ADD;
    case (op)
      OP_ADD, OP_ADDI:         ctrl = ALU_ADD;
      OP_SUB, OP_SUBI,
      OP_BEQ, OP_BNE:          ctrl = ALU_SUB;
      OP_AND, OP_ANDI:         ctrl = ALU_AND;
      OP_OR,  OP_ORI:          ctrl = ALU_OR;
      default:                 ctrl = ALU_ADD;
    endcase
    return ctrl;
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction decoder: splits the registered IR into datapath
// controls and classifies the opcode for the sequencer.
module instr_decoder
  import cpu_ctrl_pkg::*;
(
  input  logic [INSTR_W-1:0] i_ir,
  output logic [3:0]         o_ra1,
  output logic [3:0]         o_ra2,
  output logic [3:0]         o_wa,
  output logic [7:0]         o_imm,
  output logic [1:0]         o_alu_ctrl,
  output logic               o_alu_src,
  output logic               o_is_alu,
  output logic               o_is_branch,
  output logic               o_is_jump,
  output logic               o_is_halt,
  output logic               o_is_illegal
);

  opcode_e w_op;

  assign w_op       = opcode_e'(i_ir[OP_MSB:OP_LSB]);
  assign o_wa       = i_ir[WA_MSB:WA_LSB];
  assign o_ra1      = i_ir[RA1_MSB:RA1_LSB];
  assign o_imm      = i_ir[IMM_MSB:IMM_LSB];
  assign o_ra2      = i_ir[RA2_MSB:RA2_LSB];
  assign o_alu_ctrl = alu_ctrl_of(w_op);

  // Opcode classification; every flag defaults low so NOP needs no arm.
  always_comb begin
    o_alu_src    = 1'b0;
    o_is_alu     = 1'b0;
    o_is_branch  = 1'b0;
    o_is_jump    = 1'b0;
    o_is_halt    = 1'b0;
    o_is_illegal = 1'b0;
    case (w_op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        o_is_alu = 1'b1;
      end
      OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI: begin
        o_is_alu  = 1'b1;
        o_alu_src = 1'b1;
      end
      OP_BEQ, OP_BNE: o_is_branch  = 1'b1;
      OP_JMP:         o_is_jump    = 1'b1;
      OP_HALT:        o_is_halt    = 1'b1;
      OP_ILL_C, OP_ILL_D, OP_ILL_E: o_is_illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_controller.sv
// Multi-cycle fetch/decode/execute sequencer for the 8-bit CPU core.
// Optional feature: define CPU_CTRL_PERF_CNT_EN to add the 16-bit
// retired_count port counting every EXECUTE cycle.
module cpu_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int          PC_W     = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic               CLK,
  input  logic               RESET_N,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               Zero,
  output logic [3:0]         RA1,
  output logic [3:0]         RA2,
  output logic [3:0]         WA,
  output logic [7:0]         immediate,
  output logic [1:0]         ALUControl,
  output logic               ALUSrc,
  output logic               write_enable,
  output logic [PC_W-1:0]    pc_out,
`ifdef CPU_CTRL_PERF_CNT_EN
  output logic [15:0]        retired_count,
`endif
  output logic               halted,
  output logic               illegal
);

  localparam logic [PC_W-1:0] RESET_PC_V = RESET_PC[PC_W-1:0];

  state_e             r_state;
  state_e             w_state_next;
  logic [PC_W-1:0]    r_pc;
  logic [PC_W-1:0]    w_pc_next;
  logic [INSTR_W-1:0] r_ir;
  logic [INSTR_W-1:0] w_ir_next;
  logic               r_illegal;
  logic               w_illegal_next;
  // Low for the first cycle after reset release so the fetch starts one
  // clock after RESET_N deasserts rather than during reset.
  logic               r_run;

  logic [7:0]         w_imm;
  logic               w_is_alu;
  logic               w_is_branch;
  logic               w_is_jump;
  logic               w_is_halt;
  logic               w_is_illegal;
  logic               w_taken;

  instr_decoder u_decoder (
    .i_ir         (r_ir),
    .o_ra1        (RA1),
    .o_ra2        (RA2),
    .o_wa         (WA),
    .o_imm        (w_imm),
    .o_alu_ctrl   (ALUControl),
    .o_alu_src    (ALUSrc),
    .o_is_alu     (w_is_alu),
    .o_is_branch  (w_is_branch),
    .o_is_jump    (w_is_jump),
    .o_is_halt    (w_is_halt),
    .o_is_illegal (w_is_illegal)
  );

  assign immediate = w_imm;

  // BEQ uses opcode bit 0 = 1 (0x9), BNE bit 0 = 0 (0xA).
  assign w_taken = w_is_jump ||
                   (w_is_branch && (r_ir[OP_LSB] ? Zero : !Zero));

  // Outputs are functions of the asynchronously reset state, so they
  // fall the moment RESET_N asserts.
  assign imem_req     = (r_state == ST_FETCH) && r_run;
  assign imem_addr    = r_pc;
  assign pc_out       = r_pc;
  assign write_enable = (r_state == ST_EXECUTE) && w_is_alu;
  assign halted       = (r_state == ST_HALT);
  assign illegal      = r_illegal;

  // State, PC, IR and sticky flag registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state   <= ST_FETCH;
      r_pc      <= RESET_PC_V;
      r_ir      <= '0;
      r_illegal <= 1'b0;
      r_run     <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_pc      <= w_pc_next;
      r_ir      <= w_ir_next;
      r_illegal <= w_illegal_next;
      r_run     <= 1'b1;
    end
  end

  // Next-state, next-PC and IR capture for the fetch/decode/execute loop.
  always_comb begin
    w_state_next   = r_state;
    w_pc_next      = r_pc;
    w_ir_next      = r_ir;
    w_illegal_next = r_illegal;
    case (r_state)
      ST_FETCH: begin
        if (r_run && imem_valid) begin
          w_ir_next    = imem_rdata;
          w_state_next = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (w_is_illegal) begin
          w_illegal_next = 1'b1;
          w_state_next   = ST_HALT;
        end else if (w_is_halt) begin
          w_state_next = ST_HALT;
        end else begin
          w_state_next = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        if (w_taken) begin
          w_pc_next = w_imm[PC_W-1:0];
        end else begin
          w_pc_next = r_pc + PC_W'(1);
        end
        w_state_next = ST_FETCH;
      end
      ST_HALT: begin
        w_state_next = ST_HALT;
      end
      default: begin
        w_state_next = ST_FETCH;
      end
    endcase
  end

`ifdef CPU_CTRL_PERF_CNT_EN
  logic [15:0] r_retired;

  // Count every instruction that reaches EXECUTE; wraps naturally at 0xFFFF.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_retired <= 16'd0;
    end else if (r_state == ST_EXECUTE) begin
      r_retired <= r_retired + 16'd1;
    end
  end

  assign retired_count = r_retired;
`endif

endmodule
